// File: rtl/hex_scan_mux.sv
// Four-digit common-anode scan multiplexer: holds a 16-bit value and drives
// one nibble plus active-low anodes per refresh slot, with leading-zero blanking.
module hex_scan_mux #(
  parameter int DIV   = 50000,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] value,
  input  logic        blank_lz,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic [1:0]  digit_idx
);

  logic [15:0]      r_held;
  logic [CNT_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [3:0]       r_nibble;
  logic [3:0]       r_an;

  logic             w_tick;
  logic [CNT_W-1:0] w_presc_nxt;
  logic [1:0]       w_idx_nxt;
  logic [15:0]      w_held_nxt;
  logic [3:0]       w_nib_nxt;
  logic [3:0]       w_an_nxt;

  function automatic logic [3:0] nib_sel(input logic [15:0] v, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // Bit i set when digit i and every digit above it is zero; digit 0 always shows.
  function automatic logic [3:0] lz_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] && (v[11:8] == 4'h0);
    m[1] = m[2] && (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    w_tick      = en && (r_presc == CNT_W'(DIV - 1));
    w_presc_nxt = r_presc;
    if (w_tick)
      w_presc_nxt = '0;
    else if (en)
      w_presc_nxt = r_presc + 1'b1;
    w_idx_nxt  = w_tick ? r_idx + 2'd1 : r_idx;
    w_held_nxt = load ? value : r_held;
    w_nib_nxt  = nib_sel(w_held_nxt, w_idx_nxt);
    if (!en)
      w_an_nxt = 4'b1111;
    else
      w_an_nxt = ~(4'b0001 << w_idx_nxt) | (blank_lz ? lz_mask(w_held_nxt) : 4'b0000);
  end

  // Outputs register the next-state view so a load shows one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_held   <= 16'h0000;
      r_presc  <= '0;
      r_idx    <= 2'd0;
      r_nibble <= 4'h0;
      r_an     <= 4'b1110;
    end else begin
      r_held   <= w_held_nxt;
      r_presc  <= w_presc_nxt;
      r_idx    <= w_idx_nxt;
      r_nibble <= w_nib_nxt;
      r_an     <= w_an_nxt;
    end
  end

  assign nibble    = r_nibble;
  assign an        = r_an;
  assign digit_idx = r_idx;

endmodule

// File: tb/tb_hex_scan_mux.sv
// Directed bench for hex_scan_mux with DIV=4: scan order, blanking, loads,
// enable pause and asynchronous reset.
module tb_hex_scan_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] value;
  logic        blank_lz;
  logic [3:0]  nibble;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_scan_mux #(.DIV(4), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .value    (value),
    .blank_lz (blank_lz),
    .nibble   (nibble),
    .an       (an),
    .digit_idx(digit_idx)
  );

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] enib, input logic [3:0] ean,
                           input logic [1:0] eidx);
    check_val({tag, "_nib"}, 16'(nibble), 16'(enib));
    check_val({tag, "_an"}, 16'(an), 16'(ean));
    check_val({tag, "_idx"}, 16'(digit_idx), 16'(eidx));
  endtask

  // Entered with the prescaler at 3, so the first edge moves to the next digit.
  task automatic check_scan(input string tag, input int start, input int n,
                            input logic [15:0] nibs, input logic [15:0] ans);
    for (int k = 0; k < 4 * n; k++) begin
      int e;
      step(1);
      e = (start + 1 + k / 4) % 4;
      check_out(tag, nibs[4*e +: 4], ans[4*e +: 4], 2'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; value = 16'h0000; blank_lz = 1'b0;
    step(2);
    check_out("reset", 4'h0, 4'b1110, 2'd0);
    rst = 1'b0;
    step(1);
    check_out("en_low", 4'h0, 4'b1111, 2'd0);

    load = 1'b1; value = 16'hA3F1;
    step(1);
    load = 1'b0;
    check_out("load_en0", 4'h1, 4'b1111, 2'd0);

    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_out("scan_d0", 4'h1, 4'b1110, 2'd0);
    end
    check_scan("scan", 0, 4, 16'hA3F1, 16'h7BDE);

    en = 1'b0; load = 1'b1; value = 16'h0070; blank_lz = 1'b1;
    step(1);
    load = 1'b0;
    check_out("lz_load", 4'h0, 4'b1111, 2'd0);
    en = 1'b1;
    check_scan("lz70", 0, 4, 16'h0070, 16'hFFDE);

    en = 1'b0; load = 1'b1; value = 16'h0000;
    step(1);
    load = 1'b0;
    check_out("lz_load0", 4'h0, 4'b1111, 2'd0);
    en = 1'b1;
    check_scan("lz00", 0, 4, 16'h0000, 16'hFFFE);

    en = 1'b0; load = 1'b1; value = 16'h0070; blank_lz = 1'b0;
    step(1);
    load = 1'b0; en = 1'b1;
    check_scan("nolz70", 0, 4, 16'h0070, 16'h7BDE);

    step(6);
    check_out("pre_mid", 4'h0, 4'b1011, 2'd2);
    load = 1'b1; value = 16'h1234;
    step(1);
    load = 1'b0;
    check_out("mid_load", 4'h2, 4'b1011, 2'd2);
    step(1);
    check_out("mid_hold", 4'h2, 4'b1011, 2'd2);
    step(1);
    check_out("mid_tick", 4'h1, 4'b0111, 2'd3);

    step(15);
    check_out("pre_coinc", 4'h2, 4'b1011, 2'd2);
    load = 1'b1; value = 16'hABCD;
    step(1);
    load = 1'b0;
    check_out("coinc", 4'hA, 4'b0111, 2'd3);

    load = 1'b1; value = 16'h1111;
    step(1);
    value = 16'h2222;
    step(1);
    load = 1'b0;
    check_out("b2b", 4'h2, 4'b0111, 2'd3);

    step(8);
    check_out("pre_pause", 4'h2, 4'b1101, 2'd1);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check_out("pause", 4'h2, 4'b1111, 2'd1);
    end
    en = 1'b1;
    step(1);
    check_out("resume", 4'h2, 4'b1101, 2'd1);
    step(1);
    check_out("resume_tick", 4'h2, 4'b1011, 2'd2);

    load = 1'b1; value = 16'hBEEF;
    step(1);
    load = 1'b0;
    check_out("beef", 4'hE, 4'b1011, 2'd2);
    #3;
    rst = 1'b1;
    #1;
    check_out("async_rst", 4'h0, 4'b1110, 2'd0);
    step(1);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_out("rst_d0", 4'h0, 4'b1110, 2'd0);
    end
    step(1);
    check_out("rst_d1", 4'h0, 4'b1101, 2'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
